dac_cal_sequencer: RTL and testbench
====================================

# dac_cal_sequencer

Calibration sweep controller for one `eurorack-pmod`, in the `clk_256fs` domain. On a start pulse it drives `force_dac_output` through `N_STEPS` setpoints. At each step it waits a settle interval, then averages one raw ADC channel. It reports one mean per setpoint, so DAC/ADC gain and offset are measured in hardware rather than by host polling.

## Interface
Parameters:
- `W`, 16, sample width in bits.
- `N_STEPS`, 4, number of setpoints per sweep; range 1..256.
- `SETTLE_SAMPLES`, 64, sample strobes ignored after each setpoint change; minimum 1.
- `AVG_LOG2`, 6, log2 of the number of samples averaged per step; range 0..8.

Ports:
- `clk_256fs`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse; begins a sweep when idle.
- `abort`  in  1  terminates any sweep.
- `sample_strobe`  in  1  one-cycle pulse per new ADC sample, synchronous to `clk_256fs`.
- `setpoint_base`  in  W signed  first setpoint.
- `setpoint_step`  in  W signed  increment between setpoints.
- `adc_sel`  in  2  ADC channel to average (0..3).
- `sample_adc0..3`  in  W signed each  raw ADC samples.
- `force_dac_output`  out  W signed  DAC override; 0 means not forcing.
- `busy`  out  1  sweep in progress.
- `result_valid`  out  1  one-cycle pulse; `result_mean` and `result_index` are valid.
- `result_index`  out  8  step number of the result.
- `result_mean`  out  W signed  mean of the averaged samples.
- `done`  out  1  one-cycle pulse at the end of a completed (non-aborted) sweep.

## Operation
- States: IDLE, SETTLE, ACCUM, REPORT, FINISH.
- IDLE:
  - `force_dac_output`=0, `busy`=0.
  - `start`=1 latches `setpoint_base`, `setpoint_step` and `adc_sel`; index=0; force=base → SETTLE.
  - Later changes to these inputs do not affect the running sweep.
- SETTLE: counts strobes. On the `SETTLE_SAMPLES`-th strobe → ACCUM with the accumulator cleared.
- ACCUM:
  - Each strobe adds the selected `sample_adcN` (sign-extended) to an accumulator of W+AVG_LOG2 bits. Overflow is impossible by construction.
  - On the 2^AVG_LOG2-th strobe → REPORT.
- REPORT:
  - `result_mean` = accumulator >>> AVG_LOG2 (arithmetic shift, truncation toward −∞).
  - `result_index` = index; `result_valid`=1 for one cycle.
  - If index = N_STEPS−1 → FINISH. Otherwise index+1, force += step → SETTLE.
- FINISH: `done`=1 for one cycle, force=0 → IDLE.
- Setpoint arithmetic:
  - Computed in W+1 bits and saturated to [−2^(W−1), 2^(W−1)−1].
  - A computed setpoint of exactly 0 is driven as +1, because 0 would release forcing.
- `start` while not in IDLE is ignored.
- `abort` from any state:
  - → IDLE next cycle; force=0, `busy`=0.
  - No `result_valid`, no `done`.
  - `abort` has priority over `start` and over strobes in the same cycle.
- Strobes seen in IDLE, REPORT and FINISH are ignored; they are neither counted nor accumulated.

## Timing
- Reset values: all outputs 0. State IDLE, counters 0, accumulator 0.
- `start` sampled high at edge t:
  - From t+1, `busy`=1 and `force_dac_output`=base.
  - Strobes count from edge t+1 onward.
- SETTLE/ACCUM transitions occur at the clock edge that samples the qualifying strobe. The strobe that completes SETTLE is not accumulated.
- `result_valid` is high in the cycle after the final ACCUM strobe.
- New setpoint: visible the cycle after REPORT.
- `done` is high the cycle after the last REPORT. `busy` and force return to 0 the cycle after `done`.
- `result_mean` and `result_index` hold their values until the next REPORT or reset. `busy` is 0 exactly in IDLE.
- Per-step duration: SETTLE_SAMPLES + 2^AVG_LOG2 strobes, plus 1 cycle.

## Test plan
Bench parameters: `N_STEPS`=3, `SETTLE_SAMPLES`=4, `AVG_LOG2`=2, strobe every 8 cycles.
- Basic sweep:
  - Stimulus: base=1000, step=500, `adc_sel`=2, `sample_adc2` constant −300.
  - Required response: three pulses with index 0/1/2, mean −300 each; force sequence 1000, 1500, 2000; `done` once; force=0 afterwards.
- Averaging and rounding:
  - Stimulus: ACCUM samples 5, 6, 6, 6.
  - Required response: mean 5.
  - Stimulus: samples −1, 0, 0, 0.
  - Required response: mean −1.
  - Check: no sample taken during SETTLE affects the result.
- Saturation and zero substitution:
  - Stimulus: base=32000, step=1000.
  - Required response: force 32000, 32767, 32767.
  - Stimulus: base=−500, step=500.
  - Required response: second setpoint driven as 1.
- Abort:
  - Stimulus: `abort` during step 1 ACCUM, coinciding with a strobe.
  - Required response: next cycle force=0, `busy`=0; no further `result_valid` or `done`.
  - Stimulus: a new `start` afterwards.
  - Required response: sweep restarts at index 0.
- Ignored start and input changes:
  - Stimulus: `start` pulses mid-sweep; base, step and `adc_sel` changed mid-sweep.
  - Required response: sweep unaffected; the latched values are used.
- Async reset:
  - Stimulus: `rst` asserted between clock edges mid-ACCUM.
  - Required response: all outputs 0 immediately, without waiting for a clock edge; IDLE after release.

Source files
------------

// File: rtl/dac_cal_sequencer.sv
// Calibration sweep controller: steps a forced DAC setpoint, waits for settling,
// then averages one ADC channel and reports one mean per setpoint.
module dac_cal_sequencer #(
    parameter int unsigned W              = 16,
    parameter int unsigned N_STEPS        = 4,
    parameter int unsigned SETTLE_SAMPLES = 64,
    parameter int unsigned AVG_LOG2       = 6
) (
    input  logic                clk_256fs,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                sample_strobe,
    input  logic signed [W-1:0] setpoint_base,
    input  logic signed [W-1:0] setpoint_step,
    input  logic [1:0]          adc_sel,
    input  logic signed [W-1:0] sample_adc0,
    input  logic signed [W-1:0] sample_adc1,
    input  logic signed [W-1:0] sample_adc2,
    input  logic signed [W-1:0] sample_adc3,
    output logic signed [W-1:0] force_dac_output,
    output logic                busy,
    output logic                result_valid,
    output logic [7:0]          result_index,
    output logic signed [W-1:0] result_mean,
    output logic                done
);

    localparam int unsigned ACC_W  = W + AVG_LOG2;
    localparam int unsigned SET_CW = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
    localparam int unsigned AVG_CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [SET_CW-1:0] SETTLE_LAST = SET_CW'(SETTLE_SAMPLES - 1);
    localparam logic [AVG_CW-1:0] AVG_LAST    = AVG_CW'((1 << AVG_LOG2) - 1);
    localparam logic [7:0]        LAST_IDX    = 8'(N_STEPS - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StSettle = 3'd1;
    localparam logic [2:0] StAccum  = 3'd2;
    localparam logic [2:0] StReport = 3'd3;
    localparam logic [2:0] StFinish = 3'd4;

    logic [2:0]              state_q, state_d;
    logic [7:0]              idx_q, idx_d;
    logic [SET_CW-1:0]       set_cnt_q, set_cnt_d;
    logic [AVG_CW-1:0]       avg_cnt_q, avg_cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [W-1:0]     sp_q, sp_d;
    logic signed [W-1:0]     sp_next;
    logic signed [W-1:0]     step_q, step_d;
    logic [1:0]              sel_q, sel_d;
    logic signed [W-1:0]     force_q, force_d;
    logic signed [W-1:0]     mean_q, mean_d;
    logic [7:0]              rindex_q, rindex_d;
    logic signed [W-1:0]     sel_sample;

    // Sum in W+1 bits and clamp to the W-bit signed range.
    function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
        logic [W:0] sum;
        sum = {a[W-1], a} + {b[W-1], b};
        if (sum[W] != sum[W-1]) begin
            sat_add = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            sat_add = sum[W-1:0];
        end
    endfunction

    // A zero on the DAC override means "not forcing", so a zero setpoint is nudged to +1.
    function automatic logic signed [W-1:0] drive_val(input logic signed [W-1:0] sp);
        drive_val = (sp == '0) ? W'(1) : sp;
    endfunction

    always_comb begin
        sel_sample = sample_adc0;
        case (sel_q)
            2'd0:    sel_sample = sample_adc0;
            2'd1:    sel_sample = sample_adc1;
            2'd2:    sel_sample = sample_adc2;
            default: sel_sample = sample_adc3;
        endcase
    end

    assign acc_sum = acc_q + ACC_W'(sel_sample);
    assign sp_next = sat_add(sp_q, step_q);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        set_cnt_d = set_cnt_q;
        avg_cnt_d = avg_cnt_q;
        acc_d     = acc_q;
        sp_d      = sp_q;
        step_d    = step_q;
        sel_d     = sel_q;
        force_d   = force_q;
        mean_d    = mean_q;
        rindex_d  = rindex_q;

        if (abort) begin
            state_d   = StIdle;
            force_d   = '0;
            set_cnt_d = '0;
            avg_cnt_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        step_d    = setpoint_step;
                        sel_d     = adc_sel;
                        sp_d      = setpoint_base;
                        force_d   = drive_val(setpoint_base);
                        idx_d     = '0;
                        set_cnt_d = '0;
                        state_d   = StSettle;
                    end
                end
                StSettle: begin
                    if (sample_strobe) begin
                        if (set_cnt_q == SETTLE_LAST) begin
                            set_cnt_d = '0;
                            avg_cnt_d = '0;
                            acc_d     = '0;
                            state_d   = StAccum;
                        end else begin
                            set_cnt_d = set_cnt_q + SET_CW'(1);
                        end
                    end
                end
                StAccum: begin
                    if (sample_strobe) begin
                        acc_d = acc_sum;
                        if (avg_cnt_q == AVG_LAST) begin
                            // Dropping the low bits is an arithmetic shift (floor).
                            mean_d    = acc_sum[ACC_W-1:AVG_LOG2];
                            rindex_d  = idx_q;
                            avg_cnt_d = '0;
                            state_d   = StReport;
                        end else begin
                            avg_cnt_d = avg_cnt_q + AVG_CW'(1);
                        end
                    end
                end
                StReport: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = StFinish;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        sp_d    = sp_next;
                        force_d = drive_val(sp_next);
                        state_d = StSettle;
                    end
                end
                StFinish: begin
                    force_d = '0;
                    state_d = StIdle;
                end
                default: begin
                    force_d = '0;
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_256fs or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            set_cnt_q <= '0;
            avg_cnt_q <= '0;
            acc_q     <= '0;
            sp_q      <= '0;
            step_q    <= '0;
            sel_q     <= '0;
            force_q   <= '0;
            mean_q    <= '0;
            rindex_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            set_cnt_q <= set_cnt_d;
            avg_cnt_q <= avg_cnt_d;
            acc_q     <= acc_d;
            sp_q      <= sp_d;
            step_q    <= step_d;
            sel_q     <= sel_d;
            force_q   <= force_d;
            mean_q    <= mean_d;
            rindex_q  <= rindex_d;
        end
    end

    // Status pulses decode straight from state so reset clears them without a clock.
    assign busy             = (state_q != StIdle);
    assign result_valid     = (state_q == StReport);
    assign done             = (state_q == StFinish);
    assign force_dac_output = force_q;
    assign result_mean      = mean_q;
    assign result_index     = rindex_q;

endmodule

// File: tb/tb_dac_cal_sequencer.sv
// Directed, table-driven bench for dac_cal_sequencer with 3 steps, 4 settle and 4 averaged
// samples per step, strobes roughly every 8 cycles.
module tb_dac_cal_sequencer;

    localparam int W  = 16;
    localparam int NS = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic                sample_strobe = 1'b0;
    logic signed [W-1:0] setpoint_base = '0;
    logic signed [W-1:0] setpoint_step = '0;
    logic [1:0]          adc_sel = '0;
    logic signed [W-1:0] sample_adc0 = '0;
    logic signed [W-1:0] sample_adc1 = '0;
    logic signed [W-1:0] sample_adc2 = '0;
    logic signed [W-1:0] sample_adc3 = '0;
    logic signed [W-1:0] force_dac_output;
    logic                busy;
    logic                result_valid;
    logic [7:0]          result_index;
    logic signed [W-1:0] result_mean;
    logic                done;

    dac_cal_sequencer #(
        .W              (W),
        .N_STEPS        (NS),
        .SETTLE_SAMPLES (4),
        .AVG_LOG2       (2)
    ) dut (
        .clk_256fs        (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .sample_strobe    (sample_strobe),
        .setpoint_base    (setpoint_base),
        .setpoint_step    (setpoint_step),
        .adc_sel          (adc_sel),
        .sample_adc0      (sample_adc0),
        .sample_adc1      (sample_adc1),
        .sample_adc2      (sample_adc2),
        .sample_adc3      (sample_adc3),
        .force_dac_output (force_dac_output),
        .busy             (busy),
        .result_valid     (result_valid),
        .result_index     (result_index),
        .result_mean      (result_mean),
        .done             (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]       base;
        logic [15:0]       step;
        logic [1:0]        sel;
        logic [3:0][15:0]  smp;
        logic [15:0]       junk;
        logic [2:0][15:0]  f;
        logic [2:0]        fmask;
        logic [15:0]       mean;
    } vec_t;

    vec_t vecs [7];
    int   checks = 0;
    int   failures = 0;
    int   n_valid = 0;
    int   n_done = 0;

    always @(negedge clk) begin
        if (result_valid) n_valid++;
        if (done) n_done++;
    end

    function automatic vec_t mk(input int base, input int step, input int sel,
                                input int s0, input int s1, input int s2, input int s3,
                                input int junk, input int f0, input int f1, input int f2,
                                input int fmask, input int mean);
        vec_t v;
        v.base   = 16'(base);
        v.step   = 16'(step);
        v.sel    = 2'(sel);
        v.smp[0] = 16'(s0);
        v.smp[1] = 16'(s1);
        v.smp[2] = 16'(s2);
        v.smp[3] = 16'(s3);
        v.junk   = 16'(junk);
        v.f[0]   = 16'(f0);
        v.f[1]   = 16'(f1);
        v.f[2]   = 16'(f2);
        v.fmask  = 3'(fmask);
        v.mean   = 16'(mean);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive_samples(input logic [1:0] sel, input logic [15:0] val);
        sample_adc0 = (sel == 2'd0) ? val : 16'sd7777;
        sample_adc1 = (sel == 2'd1) ? val : -16'sd7777;
        sample_adc2 = (sel == 2'd2) ? val : 16'sd5555;
        sample_adc3 = (sel == 2'd3) ? val : -16'sd5555;
    endtask

    task automatic pulse(input logic [1:0] sel, input logic [15:0] val);
        repeat (7) @(negedge clk);
        drive_samples(sel, val);
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
    endtask

    task automatic start_sweep(input vec_t v);
        @(negedge clk);
        setpoint_base = v.base;
        setpoint_step = v.step;
        adc_sel       = v.sel;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", int'(busy), 1);
        if (v.fmask[0]) chk("start_force", int'(force_dac_output), int'($signed(v.f[0])));
        // Scramble the configuration inputs; the sweep must keep using the latched copies.
        setpoint_base = v.base + 16'd123;
        setpoint_step = -v.step;
        adc_sel       = v.sel ^ 2'd1;
    endtask

    task automatic run_step(input vec_t v, input int s);
        for (int k = 0; k < 4; k++) begin
            pulse(v.sel, v.junk);
            if (k == 0) begin
                if (v.fmask[s]) chk("settle_force", int'(force_dac_output), int'($signed(v.f[s])));
                chk("settle_busy", int'(busy), 1);
                chk("settle_no_valid", int'(result_valid), 0);
            end
            if (k == 1) begin
                @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        for (int k = 0; k < 4; k++) pulse(v.sel, v.smp[k]);
        chk("report_valid", int'(result_valid), 1);
        chk("report_index", int'(result_index), s);
        chk("report_mean", int'(result_mean), int'($signed(v.mean)));
        // A strobe during REPORT must be neither counted nor accumulated.
        drive_samples(v.sel, v.junk);
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        chk("valid_one_cycle", int'(result_valid), 0);
        if (s < NS - 1) begin
            if (v.fmask[s+1]) chk("next_force", int'(force_dac_output), int'($signed(v.f[s+1])));
            chk("no_early_done", int'(done), 0);
        end else begin
            chk("finish_done", int'(done), 1);
            chk("finish_busy", int'(busy), 1);
            if (v.fmask[s]) chk("finish_force_held", int'(force_dac_output), int'($signed(v.f[s])));
            @(negedge clk);
            chk("idle_done", int'(done), 0);
            chk("idle_busy", int'(busy), 0);
            chk("idle_force", int'(force_dac_output), 0);
            chk("idle_mean_hold", int'(result_mean), int'($signed(v.mean)));
        end
    endtask

    task automatic run_sweep(input vec_t v);
        int v0, d0;
        v0 = n_valid;
        d0 = n_done;
        start_sweep(v);
        for (int s = 0; s < NS; s++) run_step(v, s);
        chk("sweep_valid_count", n_valid - v0, NS);
        chk("sweep_done_count", n_done - d0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int v0, d0;
        vec_t v;
        //           base    step  sel  ---------- ACCUM samples ----------  junk    f0      f1      f2   mask  mean
        vecs[0] = mk(1000,    500, 2,   -300,   -300,   -300,   -300,   20000,  1000,   1500,   2000,  7, -300);
        vecs[1] = mk(100,     -30, 0,      5,      6,      6,      6,  -20000,   100,     70,     40,  7, 5);
        vecs[2] = mk(32000,  1000, 1,     -1,      0,      0,      0,   25000, 32000,  32767,  32767,  7, -1);
        vecs[3] = mk(-500,    500, 3,  32767,  32767,  32767,  32767,  -30000,  -500,      1,      0,  3, 32767);
        vecs[4] = mk(-1000,   500, 2, -32768, -32768, -32768, -32768,   30000, -1000,   -500,      1,  7, -32768);
        vecs[5] = mk(-32000, -1000, 0,     7,     -3,      0,      2,   12345, -32000, -32768, -32768, 7, 1);
        vecs[6] = mk(0,         3, 1,     -5,     -6,     -7,     -8,  -12345,     1,      3,      6,  7, -7);

        #1;
        chk("rst_force", int'(force_dac_output), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_index", int'(result_index), 0);
        chk("rst_mean", int'(result_mean), 0);
        chk("rst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Strobes while idle do nothing.
        pulse(2'd0, 16'sd100);
        pulse(2'd0, 16'sd100);
        chk("idle_strobe_busy", int'(busy), 0);
        chk("idle_strobe_valid_count", n_valid, 0);

        for (int i = 0; i < 7; i++) run_sweep(vecs[i]);

        // Abort on the third ACCUM strobe of step 1.
        v = vecs[0];
        start_sweep(v);
        run_step(v, 0);
        for (int k = 0; k < 4; k++) pulse(v.sel, v.junk);
        pulse(v.sel, v.smp[0]);
        pulse(v.sel, v.smp[1]);
        v0 = n_valid;
        d0 = n_done;
        repeat (7) @(negedge clk);
        drive_samples(v.sel, v.smp[2]);
        sample_strobe = 1'b1;
        abort         = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        abort         = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_force", int'(force_dac_output), 0);
        chk("abort_valid", int'(result_valid), 0);
        chk("abort_done", int'(done), 0);
        for (int k = 0; k < 6; k++) pulse(v.sel, v.smp[3]);
        chk("abort_no_valid_after", n_valid - v0, 0);
        chk("abort_no_done_after", n_done - d0, 0);
        chk("abort_still_idle", int'(busy), 0);
        run_sweep(vecs[1]);

        // Asynchronous reset between edges while in ACCUM of the last step.
        v = vecs[0];
        start_sweep(v);
        run_step(v, 0);
        run_step(v, 1);
        for (int k = 0; k < 4; k++) pulse(v.sel, v.junk);
        pulse(v.sel, v.smp[0]);
        pulse(v.sel, v.smp[1]);
        chk("pre_rst_index", int'(result_index), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_force", int'(force_dac_output), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_index", int'(result_index), 0);
        chk("arst_mean", int'(result_mean), 0);
        chk("arst_valid", int'(result_valid), 0);
        chk("arst_done", int'(done), 0);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_force", int'(force_dac_output), 0);
        run_sweep(vecs[2]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
